// File: rtl/gate_sweep_checker.sv
// gate_sweep_checker: exhaustive stimulus sequencer and response checker for
// N_IN-input gates. It sweeps every input vector PASSES times, compares the DUV
// output against the selected gate function after LATENCY cycles, and reports
// a mismatch count, the first failing vector and an overall pass flag.
// Optional feature macro: GATE_SWEEP_GRAY_EN drives o_vec in Gray code
// instead of plain binary.
module gate_sweep_checker #(
    parameter int N_IN    = 4,
    parameter int LATENCY = 0,
    parameter int GATE_OP = 0,
    parameter int PASSES  = 1
) (
    input  logic            i_clk,
    input  logic            i_rst_n,
    input  logic            i_start,
    input  logic            i_hold,
    input  logic            i_duv_f,
    output logic [N_IN-1:0] o_vec,
    output logic            o_busy,
    output logic            o_done,
    output logic            o_pass,
    output logic [15:0]     o_err_cnt,
    output logic [N_IN-1:0] o_first_err_vec
);

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    localparam logic [7:0] LAST_PASS  = 8'(PASSES - 1);
    localparam logic [3:0] DRAIN_LAST = 4'((LATENCY > 0) ? LATENCY - 1 : 0);

    state_t          state;
    state_t          state_next;
    logic [N_IN-1:0] bin_cnt;
    logic [N_IN-1:0] cur_vec;
    logic [7:0]      pass_cnt;
    logic [3:0]      drain_cnt;
    logic            issue;
    logic            last_issue;
    logic            exp_now;
    logic            cmp_valid;
    logic            cmp_exp;
    logic [N_IN-1:0] cmp_vec;
    logic            mismatch;
    logic [15:0]     err_after;

    // Reference gate function evaluated over every bit of the issued vector
    function automatic logic gate_fn(input logic [N_IN-1:0] v);
        case (GATE_OP)
            1:       return ~|v;
            2:       return &v;
            3:       return |v;
            4:       return ^v;
            5:       return ~^v;
            default: return ~&v;
        endcase
    endfunction

`ifdef GATE_SWEEP_GRAY_EN
    assign cur_vec = bin_cnt ^ (bin_cnt >> 1);
`else
    assign cur_vec = bin_cnt;
`endif

    assign o_vec      = cur_vec;
    assign o_busy     = (state == RUN) || (state == DRAIN);
    assign o_done     = (state == DONE);
    assign issue      = (state == RUN) && !i_hold;
    assign last_issue = issue && (bin_cnt == '1) && (pass_cnt == LAST_PASS);
    assign exp_now    = gate_fn(cur_vec);

    generate
        if (LATENCY == 0) begin : g_comb
            assign cmp_valid = issue;
            assign cmp_exp   = exp_now;
            assign cmp_vec   = cur_vec;
        end else begin : g_pipe
            logic [LATENCY-1:0] pipe_valid;
            logic [LATENCY-1:0] pipe_exp;
            logic [N_IN-1:0]    pipe_vec [LATENCY];

            // Delay line that aligns each issued vector with the DUV response
            always_ff @(posedge i_clk or negedge i_rst_n) begin
                if (!i_rst_n) begin
                    pipe_valid <= '0;
                    pipe_exp   <= '0;
                    for (int i = 0; i < LATENCY; i++) begin
                        pipe_vec[i] <= '0;
                    end
                end else begin
                    pipe_valid[0] <= issue;
                    pipe_exp[0]   <= exp_now;
                    pipe_vec[0]   <= cur_vec;
                    for (int i = 1; i < LATENCY; i++) begin
                        pipe_valid[i] <= pipe_valid[i-1];
                        pipe_exp[i]   <= pipe_exp[i-1];
                        pipe_vec[i]   <= pipe_vec[i-1];
                    end
                end
            end

            assign cmp_valid = pipe_valid[LATENCY-1];
            assign cmp_exp   = pipe_exp[LATENCY-1];
            assign cmp_vec   = pipe_vec[LATENCY-1];
        end
    endgenerate

    assign mismatch  = cmp_valid && (i_duv_f != cmp_exp);
    assign err_after = !mismatch ? o_err_cnt :
                       (o_err_cnt == 16'hFFFF) ? o_err_cnt : o_err_cnt + 16'd1;

    // State register
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state logic: start only in IDLE/DONE, drain skipped when combinational
    always_comb begin
        state_next = state;
        case (state)
            IDLE, DONE: begin
                if (i_start) begin
                    state_next = RUN;
                end
            end
            RUN: begin
                if (last_issue) begin
                    state_next = (LATENCY == 0) ? DONE : DRAIN;
                end
            end
            DRAIN: begin
                if (drain_cnt == DRAIN_LAST) begin
                    state_next = DONE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Sweep counters, drain timer and result registers
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            bin_cnt         <= '0;
            pass_cnt        <= '0;
            drain_cnt       <= '0;
            o_err_cnt       <= '0;
            o_first_err_vec <= '0;
            o_pass          <= 1'b0;
        end else begin
            case (state)
                IDLE, DONE: begin
                    if (i_start) begin
                        bin_cnt         <= '0;
                        pass_cnt        <= '0;
                        drain_cnt       <= '0;
                        o_err_cnt       <= '0;
                        o_first_err_vec <= '0;
                        o_pass          <= 1'b0;
                    end
                end
                RUN: begin
                    drain_cnt <= '0;
                    if (issue && !last_issue) begin
                        bin_cnt <= bin_cnt + 1'b1;
                        if (bin_cnt == '1) begin
                            pass_cnt <= pass_cnt + 8'd1;
                        end
                    end
                end
                DRAIN: begin
                    drain_cnt <= drain_cnt + 4'd1;
                end
                default: ;
            endcase

            if (o_busy) begin
                o_err_cnt <= err_after;
                if (mismatch && (o_err_cnt == 16'd0)) begin
                    o_first_err_vec <= cmp_vec;
                end
                if (state_next == DONE) begin
                    o_pass <= (err_after == 16'd0);
                end
            end
        end
    end

endmodule
